// File: rtl/instr_register_pkg.sv
// Shared types for the instruction register and its execute/read side.
package instr_register_pkg;

    localparam int unsigned RESULT_W = 64;

    typedef enum logic [3:0] {
        ZERO,
        PASSA,
        PASSB,
        ADD,
        SUB,
        MULT,
        DIV,
        MOD
    } opcode_t;

    typedef logic signed [31:0] operand_t;

    typedef struct packed {
        opcode_t  opc;
        operand_t op_a;
        operand_t op_b;
    } instruction_t;

    typedef logic signed [RESULT_W-1:0] result_t;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        EXEC,
        OUT,
        DONE
    } exec_state_t;

endpackage

// File: rtl/instr_exec_alu.sv
// Combinational executor for one instruction word: {value, err}.
// DIV/MOD are only built when INSTR_EXEC_DIVMOD_EN is defined; otherwise they report err.
module instr_exec_alu
    import instr_register_pkg::*;
#(
    parameter int unsigned RES_W = 64
) (
    input  instruction_t             iw,
    output logic signed [RES_W-1:0]  value,
    output logic                     err
);

    logic signed [RES_W-1:0] a;
    logic signed [RES_W-1:0] b;

    always_comb begin
        a     = RES_W'(iw.op_a);
        b     = RES_W'(iw.op_b);
        value = '0;
        err   = 1'b0;
        case (iw.opc)
            ZERO:  value = '0;
            PASSA: value = a;
            PASSB: value = b;
            ADD:   value = a + b;
            SUB:   value = a - b;
            MULT:  value = a * b;
`ifdef INSTR_EXEC_DIVMOD_EN
            DIV: begin
                if (b == '0) err = 1'b1;
                else         value = a / b;
            end
            MOD: begin
                if (b == '0) err = 1'b1;
                else         value = a % b;
            end
`else
            DIV, MOD: err = 1'b1;
`endif
            // Encodings outside the opcode enumeration.
            default: err = 1'b1;
        endcase
    end

endmodule

// File: rtl/instr_exec_reader.sv
// Walks a block of instr_register locations, executes each word and streams results out.
// Optional divider: INSTR_EXEC_DIVMOD_EN (see instr_exec_alu).
module instr_exec_reader
    import instr_register_pkg::*;
#(
    parameter int unsigned ADDR_W = 5,
    parameter int unsigned RES_W  = 64
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     start,
    input  logic [ADDR_W-1:0]        first_ptr,
    input  logic [ADDR_W:0]          num_instr,
    output logic [ADDR_W-1:0]        read_pointer,
    input  instruction_t             instruction_word,
    output logic                     res_valid,
    input  logic                     res_ready,
    output logic signed [RES_W-1:0]  res_value,
    output opcode_t                  res_opcode,
    output logic [ADDR_W-1:0]        res_addr,
    output logic                     res_err,
    output logic                     busy,
    output logic                     done
);

    localparam logic [ADDR_W:0]   CntOne = {{ADDR_W{1'b0}}, 1'b1};
    localparam logic [ADDR_W-1:0] PtrOne = {{(ADDR_W-1){1'b0}}, 1'b1};

    exec_state_t             state_q, state_d;
    instruction_t            iw_q;
    logic [ADDR_W:0]         remaining_q;
    logic signed [RES_W-1:0] alu_value;
    logic                    alu_err;
    logic                    handshake;

    instr_exec_alu #(
        .RES_W (RES_W)
    ) u_alu (
        .iw    (iw_q),
        .value (alu_value),
        .err   (alu_err)
    );

    assign handshake = res_valid && res_ready;
    assign busy      = (state_q != IDLE);

    always_ff @(posedge clk) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (start) state_d = (num_instr == '0) ? DONE : FETCH;
            end
            FETCH: state_d = EXEC;
            EXEC:  state_d = OUT;
            OUT: begin
                if (handshake) state_d = (remaining_q == CntOne) ? DONE : FETCH;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            read_pointer <= '0;
            remaining_q  <= '0;
            iw_q         <= '0;
            res_valid    <= 1'b0;
            res_value    <= '0;
            res_opcode   <= ZERO;
            res_addr     <= '0;
            res_err      <= 1'b0;
            done         <= 1'b0;
        end else begin
            // Registered so the pulse appears the cycle after DONE is entered.
            done <= (state_q == DONE);
            case (state_q)
                IDLE: begin
                    if (start && num_instr != '0) begin
                        read_pointer <= first_ptr;
                        remaining_q  <= num_instr;
                    end
                end
                FETCH: iw_q <= instruction_word;
                EXEC: begin
                    res_value  <= alu_value;
                    res_err    <= alu_err;
                    res_opcode <= iw_q.opc;
                    res_addr   <= read_pointer;
                    res_valid  <= 1'b1;
                end
                OUT: begin
                    if (handshake) begin
                        res_valid   <= 1'b0;
                        remaining_q <= remaining_q - CntOne;
                        if (remaining_q != CntOne) read_pointer <= read_pointer + PtrOne;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
